// File: rtl/chunk_line_bank_if.sv
// rtl/chunk_line_bank_if.sv - host byte-stream handshake bundle for chunk_line_bank
//
// Signals:
//   host_start/host_dir/host_line  stream request, direction (1 = host writes), target line
//   host_abort                     terminate the running stream
//   host_wr_valid/data/ready       host-to-bank byte handshake
//   host_rd_valid/data/ready       bank-to-host byte handshake
//   busy/done                      stream status
// Modports: master = host side, slave = bank side.
interface chunk_line_bank_if #(
    parameter int LINE_W = 2
);
    logic              host_start;
    logic              host_dir;
    logic [LINE_W-1:0] host_line;
    logic              host_abort;
    logic              host_wr_valid;
    logic [7:0]        host_wr_data;
    logic              host_wr_ready;
    logic              host_rd_valid;
    logic [7:0]        host_rd_data;
    logic              host_rd_ready;
    logic              busy;
    logic              done;

    modport master (
        output host_start, host_dir, host_line, host_abort,
        output host_wr_valid, host_wr_data, host_rd_ready,
        input  host_wr_ready, host_rd_valid, host_rd_data, busy, done
    );

    modport slave (
        input  host_start, host_dir, host_line, host_abort,
        input  host_wr_valid, host_wr_data, host_rd_ready,
        output host_wr_ready, host_rd_valid, host_rd_data, busy, done
    );
endinterface

// File: rtl/chunk_line_bank.sv
// rtl/chunk_line_bank.sv - DEPTH-line buffer between host byte streams and the matrix datapath
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-low reset
//   chunk_wr_en     write chunk_in into line chunk_wr_line (sets its valid flag)
//   chunk_wr_line   datapath write target line
//   chunk_in        datapath line data
//   chunk_rd_line   line registered onto chunk_out each cycle
//   chunk_out       registered line read data (old data on read-during-write)
//   line_valid      per-line flag: line holds a complete write
//   host            slave side of chunk_line_bank_if (byte stream handshake)
module chunk_line_bank #(
    parameter int NUM_BITS = 512,
    parameter int DEPTH    = 4,
    localparam int BYTES   = NUM_BITS / 8,
    localparam int OFF_W   = $clog2(BYTES),
    localparam int LINE_W  = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                chunk_wr_en,
    input  logic [LINE_W-1:0]   chunk_wr_line,
    input  logic [NUM_BITS-1:0] chunk_in,
    input  logic [LINE_W-1:0]   chunk_rd_line,
    output logic [NUM_BITS-1:0] chunk_out,
    output logic [DEPTH-1:0]    line_valid,
    chunk_line_bank_if.slave    host
);

    typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

    state_t              state, state_nxt;
    logic [NUM_BITS-1:0] mem [DEPTH];
    logic [LINE_W-1:0]   cur_line;
    logic [OFF_W-1:0]    ptr;
    logic [OFF_W+2:0]    bit_base;
    logic                collide;
    logic                wr_hs, rd_hs, last, start_acc;

    assign bit_base  = {ptr, 3'b000};
    assign last      = (ptr == OFF_W'(BYTES - 1));
    assign start_acc = (state == IDLE) && host.host_start;
    // A datapath write to the streamed line takes the cycle; the host byte waits.
    assign collide   = chunk_wr_en && (chunk_wr_line == cur_line);
    assign wr_hs     = host.host_wr_valid && host.host_wr_ready;
    assign rd_hs     = host.host_rd_valid && host.host_rd_ready;

    always_comb begin
        state_nxt          = state;
        host.host_wr_ready = 1'b0;
        host.host_rd_valid = 1'b0;
        host.host_rd_data  = 8'h00;
        host.busy          = (state != IDLE);
        host.done          = (state == DONE);
        case (state)
            IDLE: begin
                if (host.host_start)
                    state_nxt = host.host_dir ? WRITE : READ;
            end
            WRITE: begin
                host.host_wr_ready = !collide;
                if (host.host_abort)
                    state_nxt = IDLE;
                else if (wr_hs && last)
                    state_nxt = DONE;
            end
            READ: begin
                host.host_rd_valid = 1'b1;
                // Unlocked read: reflects datapath writes to bytes not yet sent.
                host.host_rd_data  = mem[cur_line][bit_base +: 8];
                if (host.host_abort)
                    state_nxt = IDLE;
                else if (rd_hs && last)
                    state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cur_line   <= '0;
            ptr        <= '0;
            chunk_out  <= '0;
            line_valid <= '0;
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else begin
            state     <= state_nxt;
            chunk_out <= mem[chunk_rd_line];

            if (chunk_wr_en) begin
                mem[chunk_wr_line]        <= chunk_in;
                line_valid[chunk_wr_line] <= 1'b1;
            end

            // wr_hs never coincides with a datapath write to cur_line.
            if (wr_hs)
                mem[cur_line][bit_base +: 8] <= host.host_wr_data;

            // Abort on the final byte still stores it but leaves the line unvalidated.
            if (wr_hs && last && !host.host_abort)
                line_valid[cur_line] <= 1'b1;

            // Clearing on a host write start overrides a same-cycle datapath set.
            if (start_acc && host.host_dir)
                line_valid[host.host_line] <= 1'b0;

            if (start_acc) begin
                cur_line <= host.host_line;
                ptr      <= '0;
            end else if (state == WRITE || state == READ) begin
                if (host.host_abort || ((wr_hs || rd_hs) && last))
                    ptr <= '0;
                else if (wr_hs || rd_hs)
                    ptr <= ptr + OFF_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_chunk_line_bank.sv
// tb/tb_chunk_line_bank.sv - self-checking bench for chunk_line_bank
module tb_chunk_line_bank;
    localparam int NUM_BITS = 512;
    localparam int DEPTH    = 4;
    localparam int BYTES    = NUM_BITS / 8;
    localparam int LINE_W   = 2;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                chunk_wr_en;
    logic [LINE_W-1:0]   chunk_wr_line;
    logic [NUM_BITS-1:0] chunk_in;
    logic [LINE_W-1:0]   chunk_rd_line;
    logic [NUM_BITS-1:0] chunk_out;
    logic [DEPTH-1:0]    line_valid;

    chunk_line_bank_if #(.LINE_W(LINE_W)) hif ();

    chunk_line_bank #(.NUM_BITS(NUM_BITS), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .chunk_wr_en   (chunk_wr_en),
        .chunk_wr_line (chunk_wr_line),
        .chunk_in      (chunk_in),
        .chunk_rd_line (chunk_rd_line),
        .chunk_out     (chunk_out),
        .line_valid    (line_valid),
        .host          (hif.slave)
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    logic [7:0]       m [DEPTH][BYTES];
    logic [DEPTH-1:0] mv;

    function automatic logic [NUM_BITS-1:0] model_line(int l);
        logic [NUM_BITS-1:0] v;
        for (int b = 0; b < BYTES; b++) v[8*b +: 8] = m[l][b];
        return v;
    endfunction

    function automatic logic [NUM_BITS-1:0] rand_line();
        logic [NUM_BITS-1:0] v;
        for (int w = 0; w < NUM_BITS / 32; w++) v[32*w +: 32] = $urandom;
        return v;
    endfunction

    task automatic model_load(int l, logic [NUM_BITS-1:0] d);
        for (int b = 0; b < BYTES; b++) m[l][b] = d[8*b +: 8];
        mv[l] = 1'b1;
    endtask

    task automatic model_reset();
        for (int l = 0; l < DEPTH; l++)
            for (int b = 0; b < BYTES; b++) m[l][b] = 8'h00;
        mv = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        chunk_wr_en       = 1'b0;
        chunk_wr_line     = '0;
        chunk_in          = '0;
        chunk_rd_line     = '0;
        hif.host_start    = 1'b0;
        hif.host_dir      = 1'b0;
        hif.host_line     = '0;
        hif.host_abort    = 1'b0;
        hif.host_wr_valid = 1'b0;
        hif.host_wr_data  = 8'h00;
        hif.host_rd_ready = 1'b0;
    endtask

    task automatic dp_write(int l, logic [NUM_BITS-1:0] d);
        chunk_wr_en   = 1'b1;
        chunk_wr_line = LINE_W'(l);
        chunk_in      = d;
        step();
        chunk_wr_en   = 1'b0;
        model_load(l, d);
    endtask

    task automatic start_stream(int l, logic dir);
        hif.host_start = 1'b1;
        hif.host_dir   = dir;
        hif.host_line  = LINE_W'(l);
        step();
        hif.host_start = 1'b0;
        if (dir) mv[l] = 1'b0;
    endtask

    task automatic test_reset();
        start_stream(0, 1'b1);
        for (int k = 0; k < 10; k++) begin
            hif.host_wr_valid = 1'b1;
            hif.host_wr_data  = 8'($urandom);
            step();
        end
        hif.host_wr_valid = 1'b0;
        rst = 1'b0;
        #1;
        vectors++;
        if ({hif.busy, hif.done, hif.host_wr_ready, hif.host_rd_valid} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_flags: got %b want 0000",
                     {hif.busy, hif.done, hif.host_wr_ready, hif.host_rd_valid});
        end
        vectors++;
        if (hif.host_rd_data !== 8'h00 || line_valid !== '0 || chunk_out !== '0) begin
            miscompares++;
            $display("FAIL reset_data: rd_data %h line_valid %b chunk_out_nonzero %0d want 0",
                     hif.host_rd_data, line_valid, chunk_out != '0);
        end
        step();
        rst = 1'b1;
        model_reset();
        chunk_rd_line = 2'd0;
        step();
        vectors++;
        if (hif.busy !== 1'b0 || line_valid !== '0 || chunk_out !== '0) begin
            miscompares++;
            $display("FAIL reset_release: busy %b line_valid %b chunk_out_nonzero %0d want 0",
                     hif.busy, line_valid, chunk_out != '0);
        end
    endtask

    task automatic test_host_write();
        int dones = 0;
        hif.host_start = 1'b1;
        hif.host_dir   = 1'b1;
        hif.host_line  = 2'd2;
        #1;
        vectors++;
        if (hif.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL write_busy_before: got %b want 0", hif.busy);
        end
        step();
        hif.host_start = 1'b0;
        mv[2] = 1'b0;
        vectors++;
        if (hif.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL write_busy_rise: got %b want 1", hif.busy);
        end
        for (int k = 0; k < BYTES; k++) begin
            hif.host_wr_valid = 1'b1;
            hif.host_wr_data  = 8'(k);
            #1;
            if (hif.done === 1'b1) dones++;
            vectors++;
            if (hif.host_wr_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL write_ready byte %0d: got %b want 1", k, hif.host_wr_ready);
            end
            step();
            m[2][k] = 8'(k);
        end
        hif.host_wr_valid = 1'b0;
        mv[2] = 1'b1;
        if (hif.done === 1'b1) dones++;
        vectors++;
        if (hif.host_wr_ready !== 1'b0 || hif.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL write_done_state: ready %b busy %b want 0 1", hif.host_wr_ready, hif.busy);
        end
        chunk_rd_line = 2'd2;
        step();
        if (hif.done === 1'b1) dones++;
        vectors++;
        if (dones != 1 || hif.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL write_done_pulse: pulses %0d busy %b want 1 0", dones, hif.busy);
        end
        step();
        vectors++;
        if (chunk_out !== model_line(2)) begin
            miscompares++;
            $display("FAIL write_line2: got %h want %h", chunk_out[63:0], model_line(2) >> 0);
        end
        vectors++;
        if (line_valid !== 4'b0100) begin
            miscompares++;
            $display("FAIL write_valid: got %b want 0100", line_valid);
        end
    endtask

    task automatic test_read_backpressure();
        logic [NUM_BITS-1:0] d = {BYTES{8'hA5}};
        logic [7:0] got[$];
        int idx = 0;
        int cyc = 0;
        d[7:0] = 8'h5A;
        dp_write(1, d);
        start_stream(1, 1'b0);
        while (idx < BYTES && cyc < 400) begin
            hif.host_rd_ready = cyc[0];
            #1;
            vectors++;
            if (hif.host_rd_valid !== 1'b1 || hif.host_rd_data !== m[1][idx]) begin
                miscompares++;
                $display("FAIL read_byte %0d: valid %b data %h want 1 %h",
                         idx, hif.host_rd_valid, hif.host_rd_data, m[1][idx]);
            end
            if (hif.host_rd_ready) begin
                got.push_back(hif.host_rd_data);
                idx++;
            end
            step();
            cyc++;
        end
        hif.host_rd_ready = 1'b0;
        vectors++;
        if (idx != BYTES || hif.done !== 1'b1) begin
            miscompares++;
            $display("FAIL read_complete: bytes %0d done %b want %0d 1", idx, hif.done, BYTES);
        end
        step();
        vectors++;
        if (got.size() != BYTES || got[0] !== 8'h5A || got[1] !== 8'hA5 || got[BYTES-1] !== 8'hA5) begin
            miscompares++;
            $display("FAIL read_order: size %0d first %h second %h want %0d 5a a5",
                     got.size(), got[0], got[1], BYTES);
        end
        vectors++;
        if (hif.busy !== 1'b0 || hif.done !== 1'b0) begin
            miscompares++;
            $display("FAIL read_idle: busy %b done %b want 0 0", hif.busy, hif.done);
        end
    endtask

    task automatic test_collision();
        logic [NUM_BITS-1:0] d0 = rand_line();
        logic [NUM_BITS-1:0] d1 = rand_line();
        logic pulsed = 1'b0;
        logic exp_ready;
        int k = 0;
        int cyc = 0;
        chunk_wr_en    = 1'b1;
        chunk_wr_line  = 2'd3;
        chunk_in       = d0;
        hif.host_start = 1'b1;
        hif.host_dir   = 1'b1;
        hif.host_line  = 2'd3;
        step();
        chunk_wr_en    = 1'b0;
        hif.host_start = 1'b0;
        model_load(3, d0);
        mv[3] = 1'b0;
        vectors++;
        if (line_valid[3] !== 1'b0) begin
            miscompares++;
            $display("FAIL start_clear_wins: got %b want 0", line_valid[3]);
        end
        hif.host_wr_data = 8'($urandom);
        while (k < BYTES && cyc < 200) begin
            chunk_wr_en   = (k == 30) && !pulsed;
            chunk_wr_line = 2'd3;
            chunk_in      = d1;
            hif.host_wr_valid = 1'b1;
            exp_ready = !chunk_wr_en;
            #1;
            vectors++;
            if (hif.host_wr_ready !== exp_ready) begin
                miscompares++;
                $display("FAIL collide_ready byte %0d: got %b want %b", k, hif.host_wr_ready, exp_ready);
            end
            step();
            if (chunk_wr_en) begin
                model_load(3, d1);
                pulsed = 1'b1;
            end
            if (exp_ready) begin
                m[3][k] = hif.host_wr_data;
                k++;
                hif.host_wr_data = 8'($urandom);
            end
            cyc++;
        end
        chunk_wr_en       = 1'b0;
        hif.host_wr_valid = 1'b0;
        mv[3] = 1'b1;
        vectors++;
        if (k != BYTES || hif.done !== 1'b1) begin
            miscompares++;
            $display("FAIL collide_complete: bytes %0d done %b want %0d 1", k, hif.done, BYTES);
        end
        chunk_rd_line = 2'd3;
        step();
        step();
        vectors++;
        if (chunk_out !== model_line(3) || line_valid !== mv) begin
            miscompares++;
            $display("FAIL collide_line: data_ok %0d valid %b want 1 %b",
                     chunk_out === model_line(3), line_valid, mv);
        end
    endtask

    task automatic test_abort();
        dp_write(0, rand_line());
        start_stream(0, 1'b1);
        for (int k = 0; k < 20; k++) begin
            hif.host_wr_valid = 1'b1;
            hif.host_wr_data  = 8'($urandom);
            step();
            m[0][k] = hif.host_wr_data;
        end
        hif.host_wr_valid = 1'b0;
        hif.host_abort    = 1'b1;
        step();
        hif.host_abort    = 1'b0;
        vectors++;
        if (hif.busy !== 1'b0 || hif.done !== 1'b0 || line_valid !== mv) begin
            miscompares++;
            $display("FAIL abort_state: busy %b done %b valid %b want 0 0 %b",
                     hif.busy, hif.done, line_valid, mv);
        end
        chunk_rd_line = 2'd0;
        step();
        vectors++;
        if (chunk_out !== model_line(0) || hif.done !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_line: data_ok %0d done %b want 1 0", chunk_out === model_line(0), hif.done);
        end
    endtask

    task automatic test_abort_last();
        dp_write(1, rand_line());
        start_stream(1, 1'b1);
        for (int k = 0; k < BYTES; k++) begin
            hif.host_wr_valid = 1'b1;
            hif.host_wr_data  = 8'($urandom);
            hif.host_abort    = (k == BYTES - 1);
            step();
            m[1][k] = hif.host_wr_data;
        end
        hif.host_wr_valid = 1'b0;
        hif.host_abort    = 1'b0;
        vectors++;
        if (hif.busy !== 1'b0 || hif.done !== 1'b0 || line_valid[1] !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_last_state: busy %b done %b valid1 %b want 0 0 0",
                     hif.busy, hif.done, line_valid[1]);
        end
        start_stream(1, 1'b0);
        vectors++;
        if (hif.busy !== 1'b1 || hif.host_rd_valid !== 1'b1 || hif.host_rd_data !== m[1][0]) begin
            miscompares++;
            $display("FAIL restart_read: busy %b valid %b data %h want 1 1 %h",
                     hif.busy, hif.host_rd_valid, hif.host_rd_data, m[1][0]);
        end
        hif.host_abort = 1'b1;
        step();
        hif.host_abort = 1'b0;
        chunk_rd_line  = 2'd1;
        step();
        vectors++;
        if (chunk_out !== model_line(1) || hif.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_last_line: data_ok %0d busy %b want 1 0", chunk_out === model_line(1), hif.busy);
        end
    endtask

    task automatic test_random_streams();
        for (int t = 0; t < 8; t++) begin
            int  line = $urandom_range(0, DEPTH - 1);
            logic dir = 1'($urandom_range(0, 1));
            int  idx = 0;
            int  cyc = 0;
            logic exp_ready;
            start_stream(line, dir);
            while (idx < BYTES && cyc < 600) begin
                chunk_wr_en       = ($urandom_range(0, 9) == 0);
                chunk_wr_line     = LINE_W'($urandom_range(0, DEPTH - 1));
                chunk_in          = rand_line();
                hif.host_wr_valid = dir && ($urandom_range(0, 3) != 0);
                hif.host_wr_data  = 8'($urandom);
                hif.host_rd_ready = !dir && ($urandom_range(0, 3) != 0);
                exp_ready = !(chunk_wr_en && int'(chunk_wr_line) == line);
                #1;
                vectors++;
                if (dir && hif.host_wr_ready !== exp_ready) begin
                    miscompares++;
                    $display("FAIL rand_ready t%0d byte %0d: got %b want %b", t, idx, hif.host_wr_ready, exp_ready);
                end else if (!dir && hif.host_rd_data !== m[line][idx]) begin
                    miscompares++;
                    $display("FAIL rand_rd t%0d byte %0d: got %h want %h", t, idx, hif.host_rd_data, m[line][idx]);
                end
                step();
                if (chunk_wr_en) model_load(int'(chunk_wr_line), chunk_in);
                if (dir && hif.host_wr_valid && exp_ready) begin
                    m[line][idx] = hif.host_wr_data;
                    idx++;
                end else if (!dir && hif.host_rd_ready) begin
                    idx++;
                end
                cyc++;
            end
            idle_inputs();
            if (dir) mv[line] = 1'b1;
            vectors++;
            if (idx != BYTES || hif.done !== 1'b1) begin
                miscompares++;
                $display("FAIL rand_done t%0d: bytes %0d done %b want %0d 1", t, idx, hif.done, BYTES);
                hif.host_abort = 1'b1;
                step();
                hif.host_abort = 1'b0;
            end
            step();
        end
        for (int l = 0; l < DEPTH; l++) begin
            chunk_rd_line = LINE_W'(l);
            step();
            vectors++;
            if (chunk_out !== model_line(l)) begin
                miscompares++;
                $display("FAIL rand_line %0d: got %h want %h (low 64 bits)",
                         l, chunk_out[63:0], model_line(l) & 512'hFFFF_FFFF_FFFF_FFFF);
            end
        end
        vectors++;
        if (line_valid !== mv) begin
            miscompares++;
            $display("FAIL rand_valid: got %b want %b", line_valid, mv);
        end
    endtask

    initial begin
        idle_inputs();
        model_reset();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        test_reset();
        test_host_write();
        test_read_backpressure();
        test_collision();
        test_abort();
        test_abort_last();
        test_random_streams();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
